// File: rtl/pattest_pkg.sv
// rtl/pattest_pkg.sv - shared state encoding and field widths for the pattern test sequencer
//
// Contents:
//   KEY_HS_W / CCODE_W / PAT_W  widths of the finder result fields
//   RESULT_W                    packed result width, laid out as {pat, ccode, key_hs}
//   state_t                     sequencer FSM states
//   pack_result()               builds a packed result from its three fields
package pattest_pkg;

   localparam int KEY_HS_W = 8;
   localparam int CCODE_W  = 12;
   localparam int PAT_W    = 4;
   localparam int RESULT_W = PAT_W + CCODE_W + KEY_HS_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef logic [RESULT_W-1:0] result_t;

   function automatic result_t pack_result(input logic [PAT_W-1:0]    p,
                                           input logic [CCODE_W-1:0]  c,
                                           input logic [KEY_HS_W-1:0] k);
      return {p, c, k};
   endfunction

endpackage

// File: rtl/pattest_delay.sv
// rtl/pattest_delay.sv - LATENCY-deep shift register of {valid, data} matching the finder pipeline
//
// Ports:
//   clk_i      clock
//   reset_n_i  synchronous active-low reset, clears valids and data
//   clr_i      synchronous clear of all valid bits (run abort)
//   valid_i    valid bit entering stage 0
//   data_i     payload entering stage 0 ({address, result} or just result)
//   valid_o    valid bit leaving the last stage
//   data_o     payload leaving the last stage
module pattest_delay
   import pattest_pkg::*;
#(
   parameter int LATENCY = 4,
   parameter int DW      = RESULT_W
) (
   input  logic          clk_i,
   input  logic          reset_n_i,
   input  logic          clr_i,
   input  logic          valid_i,
   input  logic [DW-1:0] data_i,
   output logic          valid_o,
   output logic [DW-1:0] data_o
);

   logic [LATENCY-1:0] valid_q;
   logic [DW-1:0]      data_q [LATENCY];

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         valid_q <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         // Payload keeps shifting on clear; only the valids need to be killed.
         for (int i = LATENCY - 1; i > 0; i--) begin
            data_q[i] <= data_q[i-1];
         end
         data_q[0] <= data_i;
         if (clr_i) begin
            valid_q <= '0;
         end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
               valid_q[i] <= valid_q[i-1];
            end
            valid_q[0] <= valid_i;
         end
      end
   end

   assign valid_o = valid_q[LATENCY-1];
   assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/pattern_test_sequencer.sv
// rtl/pattern_test_sequencer.sv - steps vector ROM through the pattern finder and scores the results
//
// Optional feature macro: PATTEST_ERRLOG_EN (first-mismatch address/result log)
//
// Ports:
//   clock, reset_n            clock and synchronous active-low reset
//   start, abort              run request (one cycle) and immediate termination
//   vec_adr, vec_inc          vector ROM address and "vector applied this cycle"
//   key_hs/ccode/pat_expect   expected result read from the ROM at vec_adr
//   key_hs, ccode, pat        finder result, LATENCY clocks after the vector
//   busy, done                run in progress, one-cycle completion pulse
//   nchecked, nerrors         saturating compare / mismatch counts for this run
//   first_err_adr/got         address and finder result of the first mismatch
module pattern_test_sequencer
   import pattest_pkg::*;
#(
   parameter int MXADRB   = 12,
   parameter int NVECTORS = 4096,
   parameter int LATENCY  = 4
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                start,
   input  logic                abort,
   output logic [MXADRB-1:0]   vec_adr,
   output logic                vec_inc,
   input  logic [KEY_HS_W-1:0] key_hs_expect,
   input  logic [CCODE_W-1:0]  ccode_expect,
   input  logic [PAT_W-1:0]    pat_expect,
   input  logic [KEY_HS_W-1:0] key_hs,
   input  logic [CCODE_W-1:0]  ccode,
   input  logic [PAT_W-1:0]    pat,
   output logic                busy,
   output logic                done,
   output logic [MXADRB:0]     nchecked,
   output logic [MXADRB:0]     nerrors,
   output logic [MXADRB-1:0]   first_err_adr,
   output logic [RESULT_W-1:0] first_err_got
);

   localparam logic [MXADRB-1:0] LAST_ADR   = MXADRB'(NVECTORS - 1);
   localparam logic [3:0]        DRAIN_LAST = 4'(LATENCY - 1);

`ifdef PATTEST_ERRLOG_EN
   localparam int DW = MXADRB + RESULT_W;
`else
   localparam int DW = RESULT_W;
`endif

   state_t              state_q;
   logic [MXADRB-1:0]   vec_adr_q;
   logic                vec_inc_q;
   logic                busy_q;
   logic                done_q;
   logic [3:0]          drain_cnt_q;
   logic [MXADRB:0]     nchecked_q, nchecked_d;
   logic [MXADRB:0]     nerrors_q, nerrors_d;

   logic                start_go;
   result_t             expect_res;
   result_t             got_res;
   logic [DW-1:0]       dl_in;
   logic [DW-1:0]       dl_out;
   logic                dl_valid;
   logic                mismatch;
   logic                cmp_en;

   // Abort beats start, and start is only honoured from IDLE.
   assign start_go = start && !abort && (state_q == ST_IDLE);

   assign expect_res = pack_result(pat_expect, ccode_expect, key_hs_expect);
   assign got_res    = pack_result(pat, ccode, key_hs);

`ifdef PATTEST_ERRLOG_EN
   assign dl_in = {vec_adr_q, expect_res};
`else
   assign dl_in = expect_res;
`endif

   pattest_delay #(
      .LATENCY (LATENCY),
      .DW      (DW)
   ) u_delay (
      .clk_i     (clock),
      .reset_n_i (reset_n),
      .clr_i     (abort),
      .valid_i   (vec_inc_q),
      .data_i    (dl_in),
      .valid_o   (dl_valid),
      .data_o    (dl_out)
   );

   assign mismatch = (dl_out[RESULT_W-1:0] != got_res);
   // A compare landing in the abort cycle is discarded so counters hold.
   assign cmp_en   = dl_valid && !abort;

   // Saturating next-count values.
   assign nchecked_d = (nchecked_q == '1) ? nchecked_q : nchecked_q + 1'b1;
   assign nerrors_d  = (nerrors_q  == '1) ? nerrors_q  : nerrors_q  + 1'b1;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         vec_adr_q   <= '0;
         vec_inc_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         drain_cnt_q <= '0;
         nchecked_q  <= '0;
         nerrors_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (abort) begin
            state_q     <= ST_IDLE;
            vec_adr_q   <= '0;
            vec_inc_q   <= 1'b0;
            busy_q      <= 1'b0;
            drain_cnt_q <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     state_q   <= ST_RUN;
                     vec_adr_q <= '0;
                     vec_inc_q <= 1'b1;
                     busy_q    <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (vec_adr_q == LAST_ADR) begin
                     state_q     <= ST_DRAIN;
                     vec_adr_q   <= '0;
                     vec_inc_q   <= 1'b0;
                     drain_cnt_q <= '0;
                  end else begin
                     vec_adr_q <= vec_adr_q + 1'b1;
                  end
               end
               ST_DRAIN: begin
                  // Last vector was issued in the final RUN cycle; LATENCY
                  // drain cycles bring its compare into the counters.
                  if (drain_cnt_q == DRAIN_LAST) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     drain_cnt_q <= drain_cnt_q + 4'd1;
                  end
               end
               ST_DONE: begin
                  state_q <= ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end

         if (start_go) begin
            nchecked_q <= '0;
            nerrors_q  <= '0;
         end else if (cmp_en) begin
            nchecked_q <= nchecked_d;
            if (mismatch) begin
               nerrors_q <= nerrors_d;
            end
         end
      end
   end

`ifdef PATTEST_ERRLOG_EN
   logic                err_seen_q;
   logic [MXADRB-1:0]   first_err_adr_q;
   result_t             first_err_got_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         err_seen_q      <= 1'b0;
         first_err_adr_q <= '0;
         first_err_got_q <= '0;
      end else if (start_go) begin
         err_seen_q      <= 1'b0;
         first_err_adr_q <= '0;
         first_err_got_q <= '0;
      end else if (cmp_en && mismatch && !err_seen_q) begin
         err_seen_q      <= 1'b1;
         first_err_adr_q <= dl_out[DW-1:RESULT_W];
         first_err_got_q <= got_res;
      end
   end

   assign first_err_adr = first_err_adr_q;
   assign first_err_got = first_err_got_q;
`else
   assign first_err_adr = '0;
   assign first_err_got = '0;
`endif

   assign vec_adr  = vec_adr_q;
   assign vec_inc  = vec_inc_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign nchecked = nchecked_q;
   assign nerrors  = nerrors_q;

endmodule

// File: doc/pattern_test_sequencer.md
# pattern_test_sequencer

Sequences a ROM-based test-vector source through the pattern finder. Steps the vector address, delays the expected key half-strip, CLCT code and pattern ID to match the finder pipeline latency, and compares them against the finder outputs. Accumulates pass/mismatch statistics. Sits between the vector ROM reader and the pattern finder in the standalone finder test harness and is controlled by a start/abort handshake from the harness or VME registers.

## Interface
Parameters:
- MXADRB, 12, vector address width
- NVECTORS, 4096, vectors per run (1..2^MXADRB)
- LATENCY, 4, finder latency in clocks, vector applied to result valid (1..15)

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset, sampled on rising edge of clock
- start  in  1  one-cycle run request
- abort  in  1  terminate run immediately
- vec_adr  out  MXADRB  address presented to vector ROM
- vec_inc  out  1  high while a vector is being applied this cycle
- key_hs_expect  in  8  expected key half-strip at vec_adr
- ccode_expect  in  12  expected CLCT code at vec_adr
- pat_expect  in  4  expected pattern ID at vec_adr
- key_hs  in  8  finder result key half-strip
- ccode  in  12  finder result CLCT code
- pat  in  4  finder result pattern ID
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run completion
- nchecked  out  MXADRB+1  vectors compared this run
- nerrors  out  MXADRB+1  mismatching vectors this run
- first_err_adr  out  MXADRB  address of first mismatch (macro-gated)
- first_err_got  out  24  {pat, ccode, key_hs} of first mismatch (macro-gated)

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: vec_adr=0, vec_inc=0. start → clear counters and error log, go to RUN.
- RUN: vec_inc=1 every cycle. vec_adr increments each cycle. The triple {pat_expect, ccode_expect, key_hs_expect} plus a valid bit enters a LATENCY-deep delay line. After the vector at address NVECTORS-1 is issued, go to DRAIN. vec_adr returns to 0 and never exceeds NVECTORS-1.
- DRAIN: vec_inc=0; LATENCY cycles, then DONE.
- DONE: done=1 for one cycle, then IDLE. Counters hold until the next start.
- Compare: when the delay-line output valid=1, compare all 24 bits against {pat, ccode, key_hs}. nchecked+1 on every compare; nerrors+1 on any bit difference. Both counters saturate at all-ones.
- start while busy: ignored. abort in any state: next state IDLE, delay-line valids cleared, counters hold, no done pulse. abort and start in the same cycle: abort wins.
- busy=1 in RUN and DRAIN.

## Timing
- Reset values: vec_adr=0, vec_inc=0, busy=0, done=0, nchecked=0, nerrors=0, first_err_adr=0, first_err_got=0, state IDLE, all delay-line valids 0.
- start sampled at edge t; RUN from t+1; first vector applied in cycle t+1.
- Vector applied in cycle c is compared in cycle c+LATENCY; counters reflect it from c+LATENCY+1.
- done asserts exactly NVECTORS+LATENCY+1 cycles after the start cycle; nchecked=NVECTORS when done=1.
- Reset mid-run: identical to power-up reset on the next edge.

## Configuration
- PATTEST_ERRLOG_EN defined: on the first compare mismatch after start, latch the compared vector's address (carried down the delay line) into first_err_adr and the finder outputs into first_err_got. Later mismatches do not overwrite these values.
- PATTEST_ERRLOG_EN undefined: first_err_adr and first_err_got are tied to 0, and the address field is not carried in the delay line.

## Structure
- Shared package pattest_pkg: FSM state encoding, field widths (KEY_HS_W=8, CCODE_W=12, PAT_W=4, RESULT_W=24).
- One sub-module, pattest_delay: a parameterized LATENCY-deep shift register of {valid, address, result}, with synchronous clear on reset or abort.

## Test plan
- NVECTORS=8, LATENCY=4, finder model equals expected → done 13 cycles after start; nchecked=8, nerrors=0.
- Same run, finder corrupts ccode at addresses 3 and 6 → nerrors=2, first_err_adr=3 (macro on) or 0 (macro off).
- abort asserted 5 cycles into the run → idle next cycle, no done pulse, busy=0, vec_adr=0.
- start re-pulsed during RUN, then start coincident with abort → no restart, abort wins.
- reset_n low mid-DRAIN → all outputs at reset values next cycle; a following start runs cleanly with nchecked=8.
- NVECTORS=4096, forced mismatch on every vector → nerrors=4096, vec_adr wraps to 0 without overflow.
